joypad_autoread: RTL and testbench

JOYPAD_AUTOREAD -- requirements
Module: joypad_autoread

---
 rtl/joypad_autoread.sv | 117 +++++++++++
 tb/tb_joypad_autoread.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/joypad_autoread.sv
// Automatic serial controller read: latches both ports, clocks 16 bits from each
// data line, and publishes all four results atomically with a one-cycle DONE.
//   state | meaning
//   IDLE  | waiting for START with AUTO_EN
//   LATCH | latch strobe high, shift clocks high
//   LOW   | shift clocks low; data sampled on the last CE tick
//   HIGH  | shift clocks high; next bit or completion
module joypad_autoread #(
  parameter int HALF = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE,
  input  logic        AUTO_EN,
  input  logic        START,
  input  logic [1:0]  PORT1_DO,
  input  logic [1:0]  PORT2_DO,
  output logic        PORT_LATCH,
  output logic        PORT1_CLK,
  output logic        PORT2_CLK,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] JOY1,
  output logic [15:0] JOY2,
  output logic [15:0] JOY3,
  output logic [15:0] JOY4
);

  localparam logic [7:0] PH_LAST = 8'(HALF - 1);

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_LOW, S_HIGH} state_t;

  state_t      state, state_nxt;
  logic [7:0]  phase_cnt;
  logic [3:0]  bit_cnt;
  logic [15:0] shadow1, shadow2, shadow3, shadow4;
  logic        phase_end;
  logic        read_end;
  logic        start_ok;

  assign phase_end = CE && (phase_cnt == PH_LAST);
  assign read_end  = (state == S_HIGH) && phase_end && (bit_cnt == 4'd15);
  assign start_ok  = START && AUTO_EN;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok)  state_nxt = S_LATCH;
      S_LATCH: if (phase_end) state_nxt = S_LOW;
      S_LOW:   if (phase_end) state_nxt = S_HIGH;
      S_HIGH:  if (phase_end) state_nxt = (bit_cnt == 4'd15) ? S_IDLE : S_LOW;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    PORT_LATCH = (state == S_LATCH);
    PORT1_CLK  = (state != S_LOW);
    PORT2_CLK  = (state != S_LOW);
    BUSY       = (state != S_IDLE);
  end

  // Phase counter restarts at every phase boundary, so it never wraps.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      phase_cnt <= 8'd0;
      bit_cnt   <= 4'd0;
    end else if (state == S_IDLE) begin
      phase_cnt <= 8'd0;
      bit_cnt   <= 4'd0;
    end else if (CE) begin
      if (phase_cnt == PH_LAST) phase_cnt <= 8'd0;
      else                      phase_cnt <= phase_cnt + 8'd1;
      if (state == S_HIGH && phase_cnt == PH_LAST)
        bit_cnt <= (bit_cnt == 4'd15) ? 4'd0 : bit_cnt + 4'd1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shadow1 <= 16'h0000;
      shadow2 <= 16'h0000;
      shadow3 <= 16'h0000;
      shadow4 <= 16'h0000;
    end else if (state == S_LOW && phase_end) begin
      shadow1 <= {shadow1[14:0], ~PORT1_DO[0]};
      shadow2 <= {shadow2[14:0], ~PORT2_DO[0]};
      shadow3 <= {shadow3[14:0], ~PORT1_DO[1]};
      shadow4 <= {shadow4[14:0], ~PORT2_DO[1]};
    end
  end

  // Results move only at completion so readers never see a partial read.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      DONE <= 1'b0;
      JOY1 <= 16'h0000;
      JOY2 <= 16'h0000;
      JOY3 <= 16'h0000;
      JOY4 <= 16'h0000;
    end else begin
      DONE <= read_end;
      if (read_end) begin
        JOY1 <= shadow1;
        JOY2 <= shadow2;
        JOY3 <= shadow3;
        JOY4 <= shadow4;
      end
    end
  end

endmodule

// File: tb/tb_joypad_autoread.sv
// Directed bench for joypad_autoread: HALF=4 and HALF=2 instances share stimulus,
// each fed by shift-register controller models loaded from pats[].
module tb_joypad_autoread;

  logic CLK, RESET, CE, AUTO_EN, START;
  logic [1:0] a_p1, a_p2, b_p1, b_p2;
  logic a_latch, a_clk1, a_clk2, a_busy, a_done;
  logic b_latch, b_clk1, b_clk2, b_busy, b_done;
  logic [15:0] a_j1, a_j2, a_j3, a_j4, b_j1, b_j2, b_j3, b_j4;

  logic [15:0] pats [4];
  logic [15:0] sra [4];
  logic [15:0] srb [4];
  int tests_run = 0;
  int fails = 0;
  int rise_a = 0;
  int fall_a = 0;
  int ce_cnt = 0;
  int ce_div = 1;

  joypad_autoread #(.HALF(4)) dut_a (
    .CLK(CLK), .RESET(RESET), .CE(CE), .AUTO_EN(AUTO_EN), .START(START),
    .PORT1_DO(a_p1), .PORT2_DO(a_p2), .PORT_LATCH(a_latch),
    .PORT1_CLK(a_clk1), .PORT2_CLK(a_clk2), .BUSY(a_busy), .DONE(a_done),
    .JOY1(a_j1), .JOY2(a_j2), .JOY3(a_j3), .JOY4(a_j4));

  joypad_autoread #(.HALF(2)) dut_b (
    .CLK(CLK), .RESET(RESET), .CE(CE), .AUTO_EN(AUTO_EN), .START(START),
    .PORT1_DO(b_p1), .PORT2_DO(b_p2), .PORT_LATCH(b_latch),
    .PORT1_CLK(b_clk1), .PORT2_CLK(b_clk2), .BUSY(b_busy), .DONE(b_done),
    .JOY1(b_j1), .JOY2(b_j2), .JOY3(b_j3), .JOY4(b_j4));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Controller models: parallel load on latch, advance on rising shift clock.
  always @(posedge a_latch) for (int i = 0; i < 4; i++) sra[i] <= ~pats[i];
  always @(posedge a_clk1) if (!a_latch) for (int i = 0; i < 4; i++) sra[i] <= {sra[i][14:0], 1'b1};
  always @(posedge b_latch) for (int i = 0; i < 4; i++) srb[i] <= ~pats[i];
  always @(posedge b_clk1) if (!b_latch) for (int i = 0; i < 4; i++) srb[i] <= {srb[i][14:0], 1'b1};
  assign a_p1 = {sra[2][15], sra[0][15]};
  assign a_p2 = {sra[3][15], sra[1][15]};
  assign b_p1 = {srb[2][15], srb[0][15]};
  assign b_p2 = {srb[3][15], srb[1][15]};

  always @(posedge a_clk1) rise_a++;
  always @(negedge a_clk1) fall_a++;

  task automatic cyc();
    @(posedge CLK);
    #1;
    ce_cnt++;
    CE = (ce_cnt % ce_div == 0);
  endtask

  task automatic settle();
    for (int k = 0; k < 500 && (a_busy || b_busy); k++) cyc();
    tests_run++;
    if (a_busy || b_busy) begin
      fails++;
      $display("FAIL settle_timeout busy_a=%0b busy_b=%0b required 0/0", a_busy, b_busy);
    end
    cyc();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    cyc(); cyc();
    tests_run++;
    if ({a_latch, a_clk1, a_clk2, a_busy, a_done} !== 5'b01100) begin
      fails++;
      $display("FAIL reset_ctrl latch/clk1/clk2/busy/done=%b required 01100",
               {a_latch, a_clk1, a_clk2, a_busy, a_done});
    end
    tests_run++;
    if ({a_j1, a_j2, a_j3, a_j4} !== 64'h0) begin
      fails++;
      $display("FAIL reset_joy got %h required 0", {a_j1, a_j2, a_j3, a_j4});
    end
    RESET = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    int lat = 0, dn = 0, dk = -1, busy0 = 0, busy_last = -1, clk_diff = 0;
    pats[0] = 16'hA5C0; pats[1] = 16'h0000; pats[2] = 16'h0000; pats[3] = 16'h0000;
    rise_a = 0; fall_a = 0;
    START = 1'b1;
    cyc();
    START = 1'b0;
    for (int k = 0; k < 140; k++) begin
      if (a_latch) lat++;
      if (a_done) begin dn++; dk = k; end
      if (a_clk1 !== a_clk2) clk_diff++;
      if (k == 0) busy0 = a_busy;
      if (k == 131) busy_last = a_busy;
      cyc();
    end
    tests_run++;
    if (dk != 132) begin fails++; $display("FAIL basic_latency got %0d required 132", dk); end
    tests_run++;
    if (dn != 1) begin fails++; $display("FAIL basic_done_pulses got %0d required 1", dn); end
    tests_run++;
    if (lat != 4) begin fails++; $display("FAIL basic_latch_len got %0d required 4", lat); end
    tests_run++;
    if (a_j1 !== 16'hA5C0) begin fails++; $display("FAIL basic_joy1 got %h required a5c0", a_j1); end
    tests_run++;
    if ({a_j2, a_j3, a_j4} !== 48'h0) begin
      fails++; $display("FAIL basic_joy234 got %h required 0", {a_j2, a_j3, a_j4});
    end
    tests_run++;
    if (busy0 != 1 || busy_last != 1 || a_busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_busy got start=%0d last=%0d after=%0b required 1/1/0", busy0, busy_last, a_busy);
    end
    tests_run++;
    if (rise_a != 16 || fall_a != 16) begin
      fails++; $display("FAIL basic_edges got rise=%0d fall=%0d required 16/16", rise_a, fall_a);
    end
    tests_run++;
    if (clk_diff != 0) begin fails++; $display("FAIL basic_clk2_match got %0d diffs required 0", clk_diff); end
  endtask

  task automatic test_four_patterns();
    int changed = 0, dn = 0;
    pats[0] = 16'h8000; pats[1] = 16'h0010; pats[2] = 16'hFFF0; pats[3] = 16'h1230;
    START = 1'b1;
    cyc();
    START = 1'b0;
    for (int k = 0; k < 140; k++) begin
      if (a_busy && {a_j1, a_j2, a_j3, a_j4} !== {16'hA5C0, 48'h0}) changed++;
      if (a_done) dn++;
      cyc();
    end
    tests_run++;
    if (changed != 0) begin fails++; $display("FAIL four_joy_stable got %0d changes required 0", changed); end
    tests_run++;
    if (dn != 1) begin fails++; $display("FAIL four_done got %0d required 1", dn); end
    tests_run++;
    if ({a_j1, a_j2, a_j3, a_j4} !== {16'h8000, 16'h0010, 16'hFFF0, 16'h1230}) begin
      fails++;
      $display("FAIL four_joy got %h %h %h %h required 8000 0010 fff0 1230", a_j1, a_j2, a_j3, a_j4);
    end
  endtask

  task automatic test_ignore_start();
    int dn = 0, busy_seen = 0;
    AUTO_EN = 1'b0;
    START = 1'b1;
    cyc();
    START = 1'b0;
    AUTO_EN = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (a_busy || b_busy) busy_seen++;
      cyc();
    end
    tests_run++;
    if (busy_seen != 0) begin fails++; $display("FAIL noen_start got busy %0d cycles required 0", busy_seen); end
    settle();
    pats[0] = 16'h1111; pats[1] = 16'h2222; pats[2] = 16'h4444; pats[3] = 16'h8888;
    rise_a = 0; fall_a = 0;
    START = 1'b1;
    cyc();
    START = 1'b0;
    busy_seen = 0;
    for (int k = 0; k < 200; k++) begin
      if (a_done) dn++;
      if (k > 132 && a_busy) busy_seen++;
      START = (k == 50 || k == 131);
      cyc();
    end
    START = 1'b0;
    tests_run++;
    if (dn != 1) begin fails++; $display("FAIL ignore_done got %0d required 1", dn); end
    tests_run++;
    if (rise_a != 16 || fall_a != 16) begin
      fails++; $display("FAIL ignore_edges got rise=%0d fall=%0d required 16/16", rise_a, fall_a);
    end
    tests_run++;
    if (busy_seen != 0) begin fails++; $display("FAIL ignore_completion_start got busy %0d required 0", busy_seen); end
    tests_run++;
    if (a_j1 !== 16'h1111 || a_j4 !== 16'h8888) begin
      fails++; $display("FAIL ignore_joy got %h %h required 1111 8888", a_j1, a_j4);
    end
    settle();
  endtask

  task automatic test_ce_div();
    int ak = -1, bk = -1;
    pats[0] = 16'h0F0F; pats[1] = 16'hF0F0; pats[2] = 16'h3C3C; pats[3] = 16'hC3C0;
    ce_div = 3;
    ce_cnt = 0;
    CE = 1'b0;
    START = 1'b1;
    cyc();
    START = 1'b0;
    for (int k = 0; k < 420; k++) begin
      if (a_done) ak = k;
      if (b_done) bk = k;
      cyc();
    end
    ce_div = 1;
    CE = 1'b1;
    tests_run++;
    if (bk != 198) begin fails++; $display("FAIL cediv_latency_b got %0d required 198", bk); end
    tests_run++;
    if (ak != 396) begin fails++; $display("FAIL cediv_latency_a got %0d required 396", ak); end
    tests_run++;
    if ({b_j1, b_j2, b_j3, b_j4} !== {16'h0F0F, 16'hF0F0, 16'h3C3C, 16'hC3C0}) begin
      fails++;
      $display("FAIL cediv_joy_b got %h %h %h %h required 0f0f f0f0 3c3c c3c0", b_j1, b_j2, b_j3, b_j4);
    end
    tests_run++;
    if (a_j3 !== 16'h3C3C) begin fails++; $display("FAIL cediv_joy_a got %h required 3c3c", a_j3); end
    settle();
  endtask

  task automatic test_reset_mid();
    int dn = 0;
    pats[0] = 16'h7777; pats[1] = 16'h6666; pats[2] = 16'h5550; pats[3] = 16'h4440;
    START = 1'b1;
    cyc();
    START = 1'b0;
    for (int k = 0; k < 62; k++) cyc();
    RESET = 1'b1;
    #1;
    tests_run++;
    if ({a_latch, a_clk1, a_clk2, a_busy, a_done} !== 5'b01100) begin
      fails++;
      $display("FAIL midreset_ctrl got %b required 01100", {a_latch, a_clk1, a_clk2, a_busy, a_done});
    end
    tests_run++;
    if ({a_j1, a_j2, a_j3, a_j4} !== 64'h0) begin
      fails++; $display("FAIL midreset_joy got %h required 0", {a_j1, a_j2, a_j3, a_j4});
    end
    cyc();
    RESET = 1'b0;
    cyc();
    pats[0] = 16'hBEEF; pats[1] = 16'hCAF0; pats[2] = 16'h0001; pats[3] = 16'hFFFF;
    START = 1'b1;
    cyc();
    START = 1'b0;
    for (int k = 0; k < 140; k++) begin
      if (a_done) dn++;
      cyc();
    end
    tests_run++;
    if (dn != 1 || {a_j1, a_j2, a_j3, a_j4} !== {16'hBEEF, 16'hCAF0, 16'h0001, 16'hFFFF}) begin
      fails++;
      $display("FAIL midreset_reread done=%0d got %h %h %h %h required 1 beef caf0 0001 ffff",
               dn, a_j1, a_j2, a_j3, a_j4);
    end
    settle();
  endtask

  task automatic test_auto_en_drop();
    int dk = -1;
    pats[0] = 16'h1357; pats[1] = 16'h2468; pats[2] = 16'h9AB0; pats[3] = 16'hDEF0;
    START = 1'b1;
    cyc();
    START = 1'b0;
    for (int k = 0; k < 140; k++) begin
      if (k == 28) AUTO_EN = 1'b0;
      if (a_done) dk = k;
      cyc();
    end
    AUTO_EN = 1'b1;
    tests_run++;
    if (dk != 132) begin fails++; $display("FAIL autoen_done got %0d required 132", dk); end
    tests_run++;
    if ({a_j1, a_j2, a_j3, a_j4} !== {16'h1357, 16'h2468, 16'h9AB0, 16'hDEF0}) begin
      fails++;
      $display("FAIL autoen_joy got %h %h %h %h required 1357 2468 9ab0 def0", a_j1, a_j2, a_j3, a_j4);
    end
  endtask

  initial begin
    RESET = 1'b1; CE = 1'b1; AUTO_EN = 1'b1; START = 1'b0;
    for (int i = 0; i < 4; i++) pats[i] = 16'h0000;
    test_reset();
    test_basic();
    settle();
    test_four_patterns();
    settle();
    test_ignore_start();
    test_ce_div();
    test_reset_mid();
    test_auto_en_drop();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
